// File: rtl/mc_control_if.sv
// Control-unit bundle: IR fields, ALU zero flag and memory ready in; datapath strobes out.
// master = control unit, slave = datapath side.
interface mc_control_if;
    logic [5:0] i_opcode;
    logic [5:0] i_funct;
    logic       i_zf;
    logic       i_mem_ready;
    logic       o_pc_write;
    logic       o_iord;
    logic       o_mem_write;
    logic       o_ir_write;
    logic       o_reg_dst;
    logic       o_mem_to_reg;
    logic       o_reg_write;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic       o_zero_ext;
    logic       o_shift_sel;
    logic [1:0] o_pc_src;
    logic [3:0] o_alu_control;
    logic       o_illegal;

    modport master (
        input  i_opcode, i_funct, i_zf, i_mem_ready,
        output o_pc_write, o_iord, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg,
               o_reg_write, o_alu_src_a, o_alu_src_b, o_zero_ext, o_shift_sel, o_pc_src,
               o_alu_control, o_illegal
    );

    modport slave (
        output i_opcode, i_funct, i_zf, i_mem_ready,
        input  o_pc_write, o_iord, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg,
               o_reg_write, o_alu_src_a, o_alu_src_b, o_zero_ext, o_shift_sel, o_pc_src,
               o_alu_control, o_illegal
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit (Moore FSM). Define MC_CONTROL_BNE_EN to add bne (opcode 0x05);
// otherwise 0x05 decodes as illegal and BRANCH is beq only.
module mc_control (
    input  logic         i_clk,
    input  logic         i_rst,
    mc_control_if.master bus
);
    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StExec, StAluWb, StBranch, StIExec, StIWb, StJump
    } state_e;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluNor  = 4'd4;
    localparam logic [3:0] AluXor  = 4'd5;
    localparam logic [3:0] AluSll  = 4'd6;
    localparam logic [3:0] AluSrl  = 4'd7;
    localparam logic [3:0] AluSltu = 4'd8;

    state_e     state_q, state_d, dispatch;
    logic       r_ok, r_shift, imm_zext;
    logic [3:0] r_alu, imm_alu;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= StFetch;
        else       state_q <= state_d;
    end

    // Instruction decode from the IR fields; only consumed in DECODE/EXEC/IEXEC.
    always_comb begin
        r_ok    = 1'b1;
        r_alu   = AluAdd;
        r_shift = 1'b0;
        case (bus.i_funct)
            6'h20, 6'h21: r_alu = AluAdd;
            6'h22, 6'h23: r_alu = AluSub;
            6'h24:        r_alu = AluAnd;
            6'h25:        r_alu = AluOr;
            6'h26:        r_alu = AluXor;
            6'h27:        r_alu = AluNor;
            6'h2B:        r_alu = AluSltu;
            6'h00: begin r_alu = AluSll; r_shift = 1'b1; end
            6'h02: begin r_alu = AluSrl; r_shift = 1'b1; end
            default:      r_ok = 1'b0;
        endcase

        imm_alu  = AluAdd;
        imm_zext = 1'b0;
        case (bus.i_opcode)
            6'h0B: imm_alu = AluSltu;
            6'h0C: begin imm_alu = AluAnd; imm_zext = 1'b1; end
            6'h0D: begin imm_alu = AluOr;  imm_zext = 1'b1; end
            6'h0E: begin imm_alu = AluXor; imm_zext = 1'b1; end
            default: ;
        endcase

        dispatch = StFetch;
        case (bus.i_opcode)
            6'h23, 6'h2B: dispatch = StMemAdr;
            6'h00:        dispatch = r_ok ? StExec : StFetch;
            6'h04:        dispatch = StBranch;
`ifdef MC_CONTROL_BNE_EN
            6'h05:        dispatch = StBranch;
`endif
            6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E: dispatch = StIExec;
            6'h02:        dispatch = StJump;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (bus.i_mem_ready) state_d = StDecode;
            StDecode: state_d = dispatch;
            StMemAdr: state_d = (bus.i_opcode == 6'h2B) ? StMemWr : StMemRd;
            StMemRd:  if (bus.i_mem_ready) state_d = StMemWb;
            StMemWr:  if (bus.i_mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StIExec:  state_d = StIWb;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        bus.o_pc_write    = 1'b0;
        bus.o_iord        = 1'b0;
        bus.o_mem_write   = 1'b0;
        bus.o_ir_write    = 1'b0;
        bus.o_reg_dst     = 1'b0;
        bus.o_mem_to_reg  = 1'b0;
        bus.o_reg_write   = 1'b0;
        bus.o_alu_src_a   = 1'b0;
        bus.o_alu_src_b   = 2'b00;
        bus.o_zero_ext    = 1'b0;
        bus.o_shift_sel   = 1'b0;
        bus.o_pc_src      = 2'b00;
        bus.o_alu_control = AluAdd;
        bus.o_illegal     = 1'b0;
        case (state_q)
            StFetch: begin
                bus.o_alu_src_b = 2'b01;
                bus.o_ir_write  = bus.i_mem_ready;
                bus.o_pc_write  = bus.i_mem_ready;
            end
            StDecode: begin
                bus.o_alu_src_b = 2'b11;
                bus.o_illegal   = (dispatch == StFetch);
            end
            StMemAdr: begin
                bus.o_alu_src_a = 1'b1;
                bus.o_alu_src_b = 2'b10;
            end
            StMemRd: bus.o_iord = 1'b1;
            StMemWb: begin
                bus.o_mem_to_reg = 1'b1;
                bus.o_reg_write  = 1'b1;
            end
            StMemWr: begin
                bus.o_iord      = 1'b1;
                bus.o_mem_write = 1'b1;
            end
            StExec: begin
                bus.o_alu_src_a   = 1'b1;
                bus.o_alu_control = r_alu;
                bus.o_shift_sel   = r_shift;
            end
            StAluWb: begin
                bus.o_reg_dst   = 1'b1;
                bus.o_reg_write = 1'b1;
            end
            StBranch: begin
                bus.o_alu_src_a   = 1'b1;
                bus.o_alu_control = AluSub;
                bus.o_pc_src      = 2'b01;
`ifdef MC_CONTROL_BNE_EN
                bus.o_pc_write    = (bus.i_opcode == 6'h05) ? !bus.i_zf : bus.i_zf;
`else
                bus.o_pc_write    = bus.i_zf;
`endif
            end
            StIExec: begin
                bus.o_alu_src_a   = 1'b1;
                bus.o_alu_src_b   = 2'b10;
                bus.o_alu_control = imm_alu;
                bus.o_zero_ext    = imm_zext;
            end
            StIWb: bus.o_reg_write = 1'b1;
            StJump: begin
                bus.o_pc_src   = 2'b10;
                bus.o_pc_write = 1'b1;
            end
            default: ;
        endcase
        // Reset is asynchronous, so the strobes must be gated combinationally too.
        if (i_rst) begin
            bus.o_pc_write  = 1'b0;
            bus.o_ir_write  = 1'b0;
            bus.o_mem_write = 1'b0;
            bus.o_reg_write = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction expected cycle traces built from the instruction
// semantics (class, CPI, stall counts), compared against the DUT every cycle.
module tb_mc_control;
    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic       shift_sel;
        logic [1:0] pc_src;
        logic [3:0] alu_control;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic  rdy;
        logic  zf;
        outs_t o;
    } step_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     n_checks = 0;
    int     n_fail = 0;
    step_t  exp_q[$];
    outs_t  dut_o;

    always #5 clk = ~clk;

    mc_control_if bus ();

    mc_control dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    assign dut_o = {bus.o_pc_write, bus.o_iord, bus.o_mem_write, bus.o_ir_write, bus.o_reg_dst,
                    bus.o_mem_to_reg, bus.o_reg_write, bus.o_alu_src_a, bus.o_alu_src_b,
                    bus.o_zero_ext, bus.o_shift_sel, bus.o_pc_src, bus.o_alu_control,
                    bus.o_illegal};

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit bne_on();
`ifdef MC_CONTROL_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // ALU code for an R-type funct, -1 when unsupported.
    function automatic int r_code(input logic [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 0;
            6'h22, 6'h23: return 1;
            6'h24: return 2;
            6'h25: return 3;
            6'h27: return 4;
            6'h26: return 5;
            6'h00: return 6;
            6'h02: return 7;
            6'h2B: return 8;
            default: return -1;
        endcase
    endfunction

    // ALU code for an I-type arithmetic opcode, -1 when not one.
    function automatic int i_code(input logic [5:0] op);
        case (op)
            6'h08, 6'h09: return 0;
            6'h0B: return 8;
            6'h0C: return 2;
            6'h0D: return 3;
            6'h0E: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic outs_t o_fetch(input logic rdy);
        outs_t o;
        o = '0;
        o.alu_src_b = 2'b01;
        o.ir_write  = rdy;
        o.pc_write  = rdy;
        return o;
    endfunction

    function automatic outs_t o_decode(input logic ill);
        outs_t o;
        o = '0;
        o.alu_src_b = 2'b11;
        o.illegal   = ill;
        return o;
    endfunction

    task automatic push(input logic rdy, input logic zf, input outs_t o);
        step_t s;
        s.rdy = rdy;
        s.zf  = zf;
        s.o   = o;
        exp_q.push_back(s);
    endtask

    // Expected per-cycle trace of one instruction; fs/ms = ready-low cycles in fetch/memory.
    task automatic plan(input logic [5:0] op, input logic [5:0] fn, input int fs, input int ms,
                        input logic zf_b);
        outs_t o;
        bus.i_opcode = op;
        bus.i_funct  = fn;
        for (int k = 0; k < fs; k++) push(1'b0, rnd(), o_fetch(1'b0));
        push(1'b1, rnd(), o_fetch(1'b1));
        if (op == 6'h23 || op == 6'h2B) begin
            push(rnd(), rnd(), o_decode(1'b0));
            o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
            push(rnd(), rnd(), o);
            o = '0; o.iord = 1'b1; o.mem_write = (op == 6'h2B);
            for (int k = 0; k < ms; k++) push(1'b0, rnd(), o);
            push(1'b1, rnd(), o);
            if (op == 6'h23) begin
                o = '0; o.mem_to_reg = 1'b1; o.reg_write = 1'b1;
                push(rnd(), rnd(), o);
            end
        end else if (op == 6'h00 && r_code(fn) >= 0) begin
            push(rnd(), rnd(), o_decode(1'b0));
            o = '0; o.alu_src_a = 1'b1; o.alu_control = 4'(r_code(fn));
            o.shift_sel = (fn == 6'h00 || fn == 6'h02);
            push(rnd(), rnd(), o);
            o = '0; o.reg_dst = 1'b1; o.reg_write = 1'b1;
            push(rnd(), rnd(), o);
        end else if (op == 6'h04 || (op == 6'h05 && bne_on())) begin
            push(rnd(), rnd(), o_decode(1'b0));
            o = '0; o.alu_src_a = 1'b1; o.alu_control = 4'd1; o.pc_src = 2'b01;
            o.pc_write = (op == 6'h04) ? zf_b : !zf_b;
            push(rnd(), zf_b, o);
        end else if (i_code(op) >= 0) begin
            push(rnd(), rnd(), o_decode(1'b0));
            o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_control = 4'(i_code(op));
            o.zero_ext = (op == 6'h0C || op == 6'h0D || op == 6'h0E);
            push(rnd(), rnd(), o);
            o = '0; o.reg_write = 1'b1;
            push(rnd(), rnd(), o);
        end else if (op == 6'h02) begin
            push(rnd(), rnd(), o_decode(1'b0));
            o = '0; o.pc_src = 2'b10; o.pc_write = 1'b1;
            push(rnd(), rnd(), o);
        end else begin
            push(rnd(), rnd(), o_decode(1'b1));
        end
    endtask

    task automatic chk(input string tag, input int idx, input outs_t e);
        n_checks++;
        assert (dut_o === e) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, idx, dut_o, e);
        end
    endtask

    // Called just after a rising edge; drives inputs, checks on the falling edge.
    task automatic run(input int max_steps, input string tag);
        step_t s;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_steps) begin
            s = exp_q.pop_front();
            bus.i_mem_ready = s.rdy;
            bus.i_zf        = s.zf;
            @(negedge clk);
            chk(tag, n, s.o);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        logic [5:0] ops [15];
        logic [5:0] fns [11];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0B,
                6'h0C, 6'h0D, 6'h0E, 6'h02, 6'h3F};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h00, 6'h02};

        bus.i_mem_ready = 1'b1;
        bus.i_zf        = 1'b0;
        bus.i_opcode    = 6'h00;
        bus.i_funct     = 6'h20;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset", k, o_fetch(1'b0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        plan(6'h00, 6'h02, 0, 0, 1'b0); run(100, "srl");
        plan(6'h23, 6'h00, 0, 2, 1'b0); run(100, "lw_stall");
        plan(6'h04, 6'h00, 0, 0, 1'b1); run(100, "beq_taken");
        plan(6'h04, 6'h00, 0, 0, 1'b0); run(100, "beq_not");
        plan(6'h05, 6'h00, 0, 0, 1'b0); run(100, "op05");
        plan(6'h0C, 6'h11, 0, 0, 1'b0); run(100, "andi");
        plan(6'h3F, 6'h20, 0, 0, 1'b0); run(100, "op3f");
        plan(6'h00, 6'h3F, 0, 0, 1'b0); run(100, "bad_funct");
        plan(6'h2B, 6'h00, 2, 1, 1'b0); run(100, "sw_stall");
        plan(6'h02, 6'h00, 1, 0, 1'b0); run(100, "jump");

        // Reset mid-lw (in MEMRD): no writeback may follow.
        plan(6'h23, 6'h00, 0, 3, 1'b0); run(4, "lw_pre");
        rst = 1'b1;
        bus.i_mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_mid", k, o_fetch(1'b0));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_q.delete();
        plan(6'h09, 6'h00, 0, 0, 1'b0); run(100, "addiu_post_rst");

        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(0, 14)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            fn = fns[$urandom_range(0, 10)];
            if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
            plan(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), rnd());
            run(100, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
